// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes and the control-field encodings
// used between the decode stage and its neighbours.
package decode_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: F/D inputs, hazard controls, writeback port and the
// registered D/E outputs. master drives the stage, slave is the stage itself.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RW   = 5
);
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic            valid_d;
    logic            stall_d;
    logic            flush_e;
    logic [RW-1:0]   a3_w;
    logic [XLEN-1:0] wd3_w;
    logic            we3_w;

    logic            valid_e;
    logic            reg_write_e;
    logic            mem_write_e;
    logic            jump_e;
    logic            branch_e;
    logic            alu_src_e;
    logic            illegal_e;
    logic [1:0]      result_src_e;
    logic [2:0]      alu_control_e;
    logic [XLEN-1:0] rd1_e;
    logic [XLEN-1:0] rd2_e;
    logic [RW-1:0]   rs1_e;
    logic [RW-1:0]   rs2_e;
    logic [RW-1:0]   rd_e;
    logic [XLEN-1:0] imm_ext_e;
    logic [XLEN-1:0] pc_e;
    logic [XLEN-1:0] pc_plus4_e;

    modport master (
        output instr_d, pc_d, pc_plus4_d, valid_d, stall_d, flush_e,
               a3_w, wd3_w, we3_w,
        input  valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
               illegal_e, result_src_e, alu_control_e, rd1_e, rd2_e, rs1_e,
               rs2_e, rd_e, imm_ext_e, pc_e, pc_plus4_e
    );

    modport slave (
        input  instr_d, pc_d, pc_plus4_d, valid_d, stall_d, flush_e,
               a3_w, wd3_w, we3_w,
        output valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
               illegal_e, result_src_e, alu_control_e, rd1_e, rd2_e, rs1_e,
               rs2_e, rd_e, imm_ext_e, pc_e, pc_plus4_e
    );
endinterface

// File: rtl/decode_stage_regfile.sv
// Register file: two combinational read ports, one write port, x0 hardwired
// to zero, optional same-cycle writeback-to-read forwarding.
module regfile #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    localparam int RW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RW-1:0]   a1,
    input  logic [RW-1:0]   a2,
    input  logic [RW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            we3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs [NREGS];

    // Writeback port; writes to x0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && a3 != '0) begin
            regs[a3] <= wd3;
        end
    end

    // Read ports with x0 masking and optional writeback forwarding
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != '0) begin
            rd1 = (BYPASS_EN != 0 && we3 && a3 == a1) ? wd3 : regs[a1];
        end
        if (a2 != '0) begin
            rd2 = (BYPASS_EN != 0 && we3 && a3 == a2) ? wd3 : regs[a2];
        end
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, main/ALU decoder, immediate extender
// and the D/E pipeline register with stall/flush/valid handling.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam int RW = $clog2(NREGS);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm_ext;
    logic            reg_write, mem_write, branch, jump, alu_src;
    logic            bad_op, bad_funct, illegal, live;
    imm_src_t        imm_src;
    result_src_t     result_src;
    alu_op_t         alu_op;
    alu_ctrl_t       alu_control;

    assign opcode  = bus.instr_d[6:0];
    assign funct3  = bus.instr_d[14:12];
    assign rs1     = bus.instr_d[15 +: RW];
    assign rs2     = bus.instr_d[20 +: RW];
    assign rd      = bus.instr_d[7 +: RW];
    assign illegal = bad_op | bad_funct;
    // Enables only propagate for a real, legal instruction
    assign live    = bus.valid_d & ~illegal;

    regfile #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .a1    (rs1),
        .a2    (rs2),
        .a3    (bus.a3_w),
        .wd3   (bus.wd3_w),
        .we3   (bus.we3_w),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Main decoder: opcode to datapath controls
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        bad_op     = 1'b0;
        imm_src    = IMM_I;
        result_src = RES_ALU;
        alu_op     = ALUOP_ADD;
        case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
            default: bad_op = 1'b1;
        endcase
    end

    // ALU decoder; subtract only for R-type with funct7[5] set
    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (opcode[5] && bus.instr_d[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: bad_funct = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Immediate extender, sign bit is always instr[31]
    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I: imm_ext = {{(XLEN-12){bus.instr_d[31]}}, bus.instr_d[31:20]};
            IMM_S: imm_ext = {{(XLEN-12){bus.instr_d[31]}}, bus.instr_d[31:25], bus.instr_d[11:7]};
            IMM_B: imm_ext = {{(XLEN-12){bus.instr_d[31]}}, bus.instr_d[7], bus.instr_d[30:25],
                              bus.instr_d[11:8], 1'b0};
            IMM_J: imm_ext = {{(XLEN-20){bus.instr_d[31]}}, bus.instr_d[19:12], bus.instr_d[20],
                              bus.instr_d[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // D/E register: flush clears enables (data holds), else stall holds, else load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_e       <= 1'b0;
            bus.reg_write_e   <= 1'b0;
            bus.mem_write_e   <= 1'b0;
            bus.jump_e        <= 1'b0;
            bus.branch_e      <= 1'b0;
            bus.alu_src_e     <= 1'b0;
            bus.illegal_e     <= 1'b0;
            bus.result_src_e  <= '0;
            bus.alu_control_e <= '0;
            bus.rd1_e         <= '0;
            bus.rd2_e         <= '0;
            bus.rs1_e         <= '0;
            bus.rs2_e         <= '0;
            bus.rd_e          <= '0;
            bus.imm_ext_e     <= '0;
            bus.pc_e          <= '0;
            bus.pc_plus4_e    <= '0;
        end else if (bus.flush_e) begin
            bus.valid_e     <= 1'b0;
            bus.reg_write_e <= 1'b0;
            bus.mem_write_e <= 1'b0;
            bus.jump_e      <= 1'b0;
            bus.branch_e    <= 1'b0;
            bus.illegal_e   <= 1'b0;
        end else if (!bus.stall_d) begin
            bus.valid_e       <= bus.valid_d;
            bus.reg_write_e   <= live & reg_write;
            bus.mem_write_e   <= live & mem_write;
            bus.jump_e        <= live & jump;
            bus.branch_e      <= live & branch;
            bus.illegal_e     <= bus.valid_d & illegal;
            bus.alu_src_e     <= alu_src;
            bus.result_src_e  <= result_src;
            bus.alu_control_e <= alu_control;
            bus.rd1_e         <= rd1;
            bus.rd2_e         <= rd2;
            bus.rs1_e         <= rs1;
            bus.rs2_e         <= rs2;
            bus.rd_e          <= rd;
            bus.imm_ext_e     <= imm_ext;
            bus.pc_e          <= bus.pc_d;
            bus.pc_plus4_e    <= bus.pc_plus4_d;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (forwarding on / off) share one
// stimulus stream; directed table, hand sequences and a random run against
// an opcode-level reference model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .RW(5)) bus_a ();
    decode_stage_if #(.XLEN(32), .RW(5)) bus_b ();

    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a)
    );
    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(0)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b)
    );

    assign bus_b.instr_d    = bus_a.instr_d;
    assign bus_b.pc_d       = bus_a.pc_d;
    assign bus_b.pc_plus4_d = bus_a.pc_plus4_d;
    assign bus_b.valid_d    = bus_a.valid_d;
    assign bus_b.stall_d    = bus_a.stall_d;
    assign bus_b.flush_e    = bus_a.flush_e;
    assign bus_b.a3_w       = bus_a.a3_w;
    assign bus_b.wd3_w      = bus_a.wd3_w;
    assign bus_b.we3_w      = bus_a.we3_w;

    typedef struct packed {
        logic [31:0] instr;
        logic        rw, mw, br, jp, ill, src;
        logic [1:0]  res;
        logic [2:0]  alu;
        logic [31:0] imm;
        bit          c_src, c_res, c_alu, c_imm;
    } vec_t;

    typedef struct packed {
        logic        valid, rw, mw, br, jp, ill, alu_src;
        logic [1:0]  res;
        logic [2:0]  alu;
        logic [31:0] imm, pc, pc4, rd1a, rd1b, rd2a, rd2b;
        logic [4:0]  rs1, rs2, rd;
        bit          c_src, c_res, c_alu, c_imm, known;
    } model_t;

    vec_t        vq[$];
    logic [31:0] mregs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                          input logic we, input logic [4:0] a3, input logic [31:0] wd,
                          input logic [31:0] pc);
        bus_a.instr_d    = ins;
        bus_a.valid_d    = v;
        bus_a.stall_d    = st;
        bus_a.flush_e    = fl;
        bus_a.we3_w      = we;
        bus_a.a3_w       = a3;
        bus_a.wd3_w      = wd;
        bus_a.pc_d       = pc;
        bus_a.pc_plus4_d = pc + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic rw, input logic mw,
                                input logic br, input logic jp, input logic ill,
                                input logic src, input logic [1:0] res, input logic [2:0] alu,
                                input logic [31:0] imm, input bit cs, input bit cr,
                                input bit ca, input bit ci);
        vec_t v;
        v.instr = ins; v.rw = rw; v.mw = mw; v.br = br; v.jp = jp; v.ill = ill;
        v.src = src; v.res = res; v.alu = alu; v.imm = imm;
        v.c_src = cs; v.c_res = cr; v.c_alu = ca; v.c_imm = ci;
        return v;
    endfunction

    // Opcode-level reference: what the instruction means, not how it is decoded
    function automatic model_t ref_decode(input logic [31:0] ins, input logic v);
        model_t m;
        logic [6:0] op;
        logic [2:0] f3;
        bit legal, w, mw, b, j;
        m = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        legal = 1; w = 0; mw = 0; b = 0; j = 0;
        m.rs1 = ins[19:15];
        m.rs2 = ins[24:20];
        m.rd  = ins[11:7];
        case (op)
            7'h03: begin
                w = 1; m.alu_src = 1; m.c_src = 1; m.res = 2'b01; m.c_res = 1;
                m.alu = 3'b000; m.c_alu = 1;
                m.imm = 32'($signed(ins[31:20])); m.c_imm = 1;
            end
            7'h23: begin
                mw = 1; m.alu_src = 1; m.c_src = 1; m.alu = 3'b000; m.c_alu = 1;
                m.imm = 32'($signed({ins[31:25], ins[11:7]})); m.c_imm = 1;
            end
            7'h33, 7'h13: begin
                w = 1; m.alu_src = (op == 7'h13); m.c_src = 1; m.res = 2'b00; m.c_res = 1;
                if (op == 7'h13) begin
                    m.imm = 32'($signed(ins[31:20])); m.c_imm = 1;
                end
                case (f3)
                    3'd0: m.alu = (op == 7'h33 && ins[30]) ? 3'b001 : 3'b000;
                    3'd2: m.alu = 3'b101;
                    3'd6: m.alu = 3'b011;
                    3'd7: m.alu = 3'b010;
                    default: legal = 0;
                endcase
                m.c_alu = legal;
            end
            7'h63: begin
                b = 1; m.alu_src = 0; m.c_src = 1; m.alu = 3'b001; m.c_alu = 1;
                m.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); m.c_imm = 1;
            end
            7'h6F: begin
                w = 1; j = 1; m.res = 2'b10; m.c_res = 1;
                m.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); m.c_imm = 1;
            end
            default: legal = 0;
        endcase
        m.valid = v;
        m.ill   = v && !legal;
        m.rw    = v && legal && w;
        m.mw    = v && legal && mw;
        m.br    = v && legal && b;
        m.jp    = v && legal && j;
        return m;
    endfunction

    function automatic logic [31:0] read_ref(input logic [4:0] a, input bit fwd, input logic we,
                                             input logic [4:0] a3, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (fwd && we && a3 == a) return wd;
        return mregs[a];
    endfunction

    initial begin
        model_t expv, nxt;
        logic [31:0] r, ins, wd, pc;
        logic [6:0]  op;
        logic [4:0]  a3;
        logic        v, st, fl, we;

        set_in(32'd0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        #1;
        chk("rst.valid", bus_a.valid_e, 0);
        chk("rst.rd1", bus_a.rd1_e, 0);
        chk("rst.imm", bus_a.imm_ext_e, 0);
        chk("rst.pc4", bus_a.pc_plus4_e, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed decode table
        vq.push_back(mk(32'h000280B3, 1,0,0,0,0, 0, 2'b00, 3'b000, 32'h0,        1,1,1,0));
        vq.push_back(mk(32'hFFC0A103, 1,0,0,0,0, 1, 2'b01, 3'b000, 32'hFFFFFFFC, 1,1,1,1));
        vq.push_back(mk(32'h00512423, 0,1,0,0,0, 1, 2'b00, 3'b000, 32'h00000008, 1,0,1,1));
        vq.push_back(mk(32'hFE208CE3, 0,0,1,0,0, 0, 2'b00, 3'b001, 32'hFFFFFFF8, 1,0,1,1));
        vq.push_back(mk(32'h001000EF, 1,0,0,1,0, 0, 2'b10, 3'b000, 32'h00000800, 0,1,0,1));
        vq.push_back(mk(32'hFFF08193, 1,0,0,0,0, 1, 2'b00, 3'b000, 32'hFFFFFFFF, 1,1,1,1));
        vq.push_back(mk(32'h402081B3, 1,0,0,0,0, 0, 2'b00, 3'b001, 32'h0,        1,1,1,0));
        vq.push_back(mk(32'h0020A1B3, 1,0,0,0,0, 0, 2'b00, 3'b101, 32'h0,        1,1,1,0));
        vq.push_back(mk(32'h0020E1B3, 1,0,0,0,0, 0, 2'b00, 3'b011, 32'h0,        1,1,1,0));
        vq.push_back(mk(32'h0020F1B3, 1,0,0,0,0, 0, 2'b00, 3'b010, 32'h0,        1,1,1,0));
        vq.push_back(mk(32'h40008193, 1,0,0,0,0, 1, 2'b00, 3'b000, 32'h00000400, 1,1,1,1));
        vq.push_back(mk(32'h0000007F, 0,0,0,0,1, 0, 2'b00, 3'b000, 32'h0,        0,0,0,0));
        vq.push_back(mk(32'h002091B3, 0,0,0,0,1, 0, 2'b00, 3'b000, 32'h0,        0,0,0,0));
        vq.push_back(mk(32'h0010D193, 0,0,0,0,1, 0, 2'b00, 3'b000, 32'h0,        0,0,0,0));
        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].instr, 1, 0, 0, 0, 5'd0, 32'd0, 32'h1000 + 32'(i * 4));
            step();
            chk($sformatf("vec%0d.valid", i), bus_a.valid_e, 1);
            chk($sformatf("vec%0d.rw", i), bus_a.reg_write_e, vq[i].rw);
            chk($sformatf("vec%0d.mw", i), bus_a.mem_write_e, vq[i].mw);
            chk($sformatf("vec%0d.br", i), bus_a.branch_e, vq[i].br);
            chk($sformatf("vec%0d.jp", i), bus_a.jump_e, vq[i].jp);
            chk($sformatf("vec%0d.ill", i), bus_a.illegal_e, vq[i].ill);
            chk($sformatf("vec%0d.pc", i), bus_a.pc_e, 32'h1000 + 32'(i * 4));
            chk($sformatf("vec%0d.pc4", i), bus_a.pc_plus4_e, 32'h1004 + 32'(i * 4));
            if (vq[i].c_src) chk($sformatf("vec%0d.src", i), bus_a.alu_src_e, vq[i].src);
            if (vq[i].c_res) chk($sformatf("vec%0d.res", i), bus_a.result_src_e, vq[i].res);
            if (vq[i].c_alu) chk($sformatf("vec%0d.alu", i), bus_a.alu_control_e, vq[i].alu);
            if (vq[i].c_imm) chk($sformatf("vec%0d.imm", i), bus_a.imm_ext_e, vq[i].imm);
        end

        // Writeback then read
        set_in(32'd0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 32'd0);
        step();
        set_in(32'h000280B3, 1, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        step();
        chk("wb.rd1a", bus_a.rd1_e, 32'hDEADBEEF);
        chk("wb.rd1b", bus_b.rd1_e, 32'hDEADBEEF);
        chk("wb.alu", bus_a.alu_control_e, 3'b000);
        chk("wb.rw", bus_a.reg_write_e, 1);
        chk("wb.rd", bus_a.rd_e, 5'd1);
        chk("wb.rs1", bus_a.rs1_e, 5'd5);

        // Same-cycle forwarding
        set_in(32'h000300B3, 1, 0, 0, 1, 5'd6, 32'h12345678, 32'd0);
        step();
        chk("byp.rd1a", bus_a.rd1_e, 32'h12345678);
        chk("byp.rd1b", bus_b.rd1_e, 32'h0);
        set_in(32'h000300B3, 1, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        step();
        chk("byp.after_b", bus_b.rd1_e, 32'h12345678);
        set_in(32'h000000B3, 1, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 32'd0);
        step();
        chk("byp.x0a", bus_a.rd1_e, 32'h0);
        chk("byp.x0b", bus_b.rd1_e, 32'h0);

        // Stall holds E, no re-read even when the source is written
        set_in(32'hFFF08193, 1, 0, 0, 0, 5'd0, 32'd0, 32'h300);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in($urandom, 1, 1, 0, 1, 5'd1, $urandom | 32'h1, 32'h400 + 32'(i));
            step();
            chk($sformatf("stall%0d.valid", i), bus_a.valid_e, 1);
            chk($sformatf("stall%0d.rw", i), bus_a.reg_write_e, 1);
            chk($sformatf("stall%0d.rd", i), bus_a.rd_e, 5'd3);
            chk($sformatf("stall%0d.imm", i), bus_a.imm_ext_e, 32'hFFFFFFFF);
            chk($sformatf("stall%0d.rd1", i), bus_a.rd1_e, 32'h0);
            chk($sformatf("stall%0d.pc", i), bus_a.pc_e, 32'h300);
        end
        set_in(32'h000280B3, 1, 1, 1, 0, 5'd0, 32'd0, 32'd0);
        step();
        chk("stfl.valid", bus_a.valid_e, 0);
        chk("stfl.rw", bus_a.reg_write_e, 0);
        set_in(32'h000280B3, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        step();
        chk("bubble.valid", bus_a.valid_e, 0);
        chk("bubble.rw", bus_a.reg_write_e, 0);
        set_in(32'h0000007F, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        step();
        chk("bubble.ill", bus_a.illegal_e, 0);

        // Asynchronous reset mid-run
        set_in(32'hFFC0A103, 1, 0, 0, 0, 5'd0, 32'd0, 32'h2000);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", bus_a.valid_e, 0);
        chk("arst.rw", bus_a.reg_write_e, 0);
        chk("arst.res", bus_a.result_src_e, 0);
        chk("arst.imm", bus_a.imm_ext_e, 0);
        chk("arst.pc", bus_a.pc_e, 0);
        chk("arst.rd", bus_a.rd_e, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(32'h000280B3, 1, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        step();
        chk("arst.x5a", bus_a.rd1_e, 32'h0);
        chk("arst.x5b", bus_b.rd1_e, 32'h0);

        // Random run against the reference model
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        set_in(32'd0, 0, 0, 1, 0, 5'd0, 32'd0, 32'd0);
        step();
        expv = '0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0: op = 7'h03;
                1: op = 7'h23;
                2: op = 7'h33;
                3: op = 7'h63;
                4: op = 7'h13;
                5: op = 7'h6F;
                6: op = r[6:0];
                default: begin
                    op = 7'h33;
                    r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                end
            endcase
            ins = {r[31:7], op};
            v   = ($urandom_range(0, 9) < 8);
            st  = ($urandom_range(0, 9) < 2);
            fl  = ($urandom_range(0, 9) == 0);
            we  = ($urandom_range(0, 1) != 0);
            a3  = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 31));
            wd  = $urandom;
            pc  = $urandom;
            set_in(ins, v, st, fl, we, a3, wd, pc);

            nxt = expv;
            if (fl) begin
                nxt.valid = 0; nxt.rw = 0; nxt.mw = 0; nxt.br = 0; nxt.jp = 0; nxt.ill = 0;
                nxt.known = 0;
            end else if (!st) begin
                nxt = ref_decode(ins, v);
                nxt.pc   = pc;
                nxt.pc4  = pc + 32'd4;
                nxt.rd1a = read_ref(ins[19:15], 1, we, a3, wd);
                nxt.rd1b = read_ref(ins[19:15], 0, we, a3, wd);
                nxt.rd2a = read_ref(ins[24:20], 1, we, a3, wd);
                nxt.rd2b = read_ref(ins[24:20], 0, we, a3, wd);
                nxt.known = 1;
            end
            step();
            if (we && a3 != 5'd0) mregs[a3] = wd;
            expv = nxt;

            chk($sformatf("rnd%0d.valid", n), bus_a.valid_e, expv.valid);
            chk($sformatf("rnd%0d.rw", n), bus_a.reg_write_e, expv.rw);
            chk($sformatf("rnd%0d.mw", n), bus_a.mem_write_e, expv.mw);
            chk($sformatf("rnd%0d.br", n), bus_a.branch_e, expv.br);
            chk($sformatf("rnd%0d.jp", n), bus_a.jump_e, expv.jp);
            chk($sformatf("rnd%0d.ill", n), bus_a.illegal_e, expv.ill);
            if (expv.known) begin
                chk($sformatf("rnd%0d.rs1", n), bus_a.rs1_e, expv.rs1);
                chk($sformatf("rnd%0d.rs2", n), bus_a.rs2_e, expv.rs2);
                chk($sformatf("rnd%0d.rd", n), bus_a.rd_e, expv.rd);
                chk($sformatf("rnd%0d.pc", n), bus_a.pc_e, expv.pc);
                chk($sformatf("rnd%0d.pc4", n), bus_a.pc_plus4_e, expv.pc4);
                chk($sformatf("rnd%0d.rd1a", n), bus_a.rd1_e, expv.rd1a);
                chk($sformatf("rnd%0d.rd1b", n), bus_b.rd1_e, expv.rd1b);
                chk($sformatf("rnd%0d.rd2a", n), bus_a.rd2_e, expv.rd2a);
                chk($sformatf("rnd%0d.rd2b", n), bus_b.rd2_e, expv.rd2b);
                if (expv.c_src) chk($sformatf("rnd%0d.src", n), bus_a.alu_src_e, expv.alu_src);
                if (expv.c_res) chk($sformatf("rnd%0d.res", n), bus_a.result_src_e, expv.res);
                if (expv.c_alu) chk($sformatf("rnd%0d.alu", n), bus_a.alu_control_e, expv.alu);
                if (expv.c_imm) chk($sformatf("rnd%0d.imm", n), bus_a.imm_ext_e, expv.imm);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
